// File: rtl/bcnt_mon_if.sv
// bcnt_mon_if: sample/event bundle between a counter source and the bcnt_mon monitor
// master drives in_vld/in_val/clr and reads the monitor results; slave is the monitor side.
interface bcnt_mon_if #(parameter int CNT_W = 8);
    logic             in_vld;
    logic [3:0]       in_val;
    logic             clr;
    logic             locked;
    logic             dir;
    logic             err_pulse;
    logic             wrap_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] wrap_cnt;
    modport master (
        output in_vld, in_val, clr,
        input  locked, dir, err_pulse, wrap_pulse, err_cnt, wrap_cnt
    );
    modport slave (
        input  in_vld, in_val, clr,
        output locked, dir, err_pulse, wrap_pulse, err_cnt, wrap_cnt
    );
endinterface

// File: rtl/bcnt_mon.sv
// bcnt_mon: locks onto the direction of a 4-bit up/down counter and flags step errors and wraps
// clk, rst        : clock, synchronous active-high reset
// bus.in_vld/val  : qualified sample of the observed counter
// bus.clr         : synchronous clear of err_cnt/wrap_cnt
// bus.locked/dir  : tracking status and direction (0 up, 1 down), registered
// bus.err_pulse/wrap_pulse, err_cnt/wrap_cnt : event flags and saturating counters, registered
module bcnt_mon #(
    parameter int LOCK_N = 2,
    parameter int CNT_W  = 8
) (
    input logic       clk,
    input logic       rst,
    bcnt_mon_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SYNC, LOCK} state_t;
    localparam logic [2:0] LOCK_M = 3'(LOCK_N);
    state_t           state, state_n;
    logic [3:0]       prev, prev_n;
    logic [2:0]       match, match_n;
    logic             cand, cand_n;
    logic             locked_n, dir_n, err_n, wrap_n;
    logic [CNT_W-1:0] err_cnt_n, wrap_cnt_n;
    logic             step_up, step_dn, hit, is_wrap;
    assign step_up = bus.in_val == prev + 4'd1;
    assign step_dn = bus.in_val == prev - 4'd1;
    assign hit     = bus.dir ? step_dn : step_up;
    assign is_wrap = bus.dir ? prev == 4'd0 : prev == 4'd15;
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            prev           <= '0;
            match          <= '0;
            cand           <= 1'b0;
            bus.locked     <= 1'b0;
            bus.dir        <= 1'b0;
            bus.err_pulse  <= 1'b0;
            bus.wrap_pulse <= 1'b0;
            bus.err_cnt    <= '0;
            bus.wrap_cnt   <= '0;
        end else begin
            state          <= state_n;
            prev           <= prev_n;
            match          <= match_n;
            cand           <= cand_n;
            bus.locked     <= locked_n;
            bus.dir        <= dir_n;
            bus.err_pulse  <= err_n;
            bus.wrap_pulse <= wrap_n;
            bus.err_cnt    <= err_cnt_n;
            bus.wrap_cnt   <= wrap_cnt_n;
        end
    end
    always_comb begin
        state_n = state;
        prev_n  = prev;
        match_n = match;
        cand_n  = cand;
        if (bus.in_vld) begin
            prev_n = bus.in_val;
            if (state == IDLE) begin
                match_n = '0;
                state_n = SYNC;
            end else if (state == SYNC) begin
                cand_n  = step_up ? 1'b0 : step_dn ? 1'b1 : cand;
                // a step only extends the run if it continues the same direction
                match_n = !(step_up || step_dn) ? 3'd0 :
                          (match != 3'd0 && cand == cand_n) ? match + 3'd1 : 3'd1;
                if (match_n == LOCK_M) state_n = LOCK;
            end else if (!hit) begin
                match_n = '0;
                state_n = SYNC;
            end
        end
    end
    always_comb begin
        locked_n   = bus.locked;
        dir_n      = bus.dir;
        err_n      = 1'b0;
        wrap_n     = 1'b0;
        err_cnt_n  = bus.err_cnt;
        wrap_cnt_n = bus.wrap_cnt;
        if (bus.in_vld && state == SYNC && state_n == LOCK) begin
            locked_n = 1'b1;
            dir_n    = cand_n;
        end
        if (bus.in_vld && state == LOCK) begin
            err_n    = !hit;
            wrap_n   = hit && is_wrap;
            locked_n = hit;
        end
        if (err_n && bus.err_cnt != '1) err_cnt_n = bus.err_cnt + 1'b1;
        if (wrap_n && bus.wrap_cnt != '1) wrap_cnt_n = bus.wrap_cnt + 1'b1;
        if (bus.clr) begin
            err_cnt_n  = '0;
            wrap_cnt_n = '0;
        end
    end
endmodule

// File: tb/tb_bcnt_mon.sv
// tb_bcnt_mon: scoreboard bench for bcnt_mon against a step-rule reference model
module tb_bcnt_mon;
    localparam int LOCK_N = 2;
    localparam int CNT_W  = 8;
    localparam int SAT    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       locked;
        logic       dir;
        logic       errp;
        logic       wrapp;
        logic [7:0] errc;
        logic [7:0] wrapc;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcnt_mon_if #(.CNT_W(CNT_W)) bus();
    bcnt_mon #(.LOCK_N(LOCK_N), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // reference model: "have" = a previous sample exists, run = consecutive
    // same-direction unit steps seen while not locked
    bit m_have, m_lock, m_dir, m_cand, m_errp, m_wrapp;
    int m_prev, m_run, m_errc, m_wrapc;

    function automatic void model(bit r, bit v, int val, bit c);
        int d;
        bit nd;
        m_errp  = 0;
        m_wrapp = 0;
        if (r) begin
            m_have = 0; m_lock = 0; m_dir = 0; m_cand = 0;
            m_prev = 0; m_run = 0; m_errc = 0; m_wrapc = 0;
            return;
        end
        if (v) begin
            d = (val - m_prev) & 15;
            if (!m_have) begin
                m_have = 1;
                m_run  = 0;
            end else if (!m_lock) begin
                if (d == 1 || d == 15) begin
                    nd     = (d == 15);
                    m_run  = (m_run > 0 && m_cand == nd) ? m_run + 1 : 1;
                    m_cand = nd;
                end else m_run = 0;
                if (m_run == LOCK_N) begin
                    m_lock = 1;
                    m_dir  = m_cand;
                end
            end else if (d == (m_dir ? 15 : 1)) begin
                m_wrapp = (val == (m_dir ? 15 : 0));
                if (m_wrapp && m_wrapc < SAT) m_wrapc++;
            end else begin
                m_errp = 1;
                if (m_errc < SAT) m_errc++;
                m_lock = 0;
                m_run  = 0;
            end
            m_prev = val;
        end
        if (c) begin
            m_errc  = 0;
            m_wrapc = 0;
        end
    endfunction

    task automatic drive(bit r, bit v, int val, bit c);
        @(negedge clk);
        rst        = r;
        bus.in_vld = v;
        bus.in_val = 4'(val);
        bus.clr    = c;
        model(r, v, val, c);
        exp_q.push_back(obs_t'{m_lock, m_dir, m_errp, m_wrapp, 8'(m_errc), 8'(m_wrapc)});
    endtask

    task automatic sample(int val);
        drive(0, 1, val & 15, 0);
    endtask

    task automatic settle;
        @(posedge clk);
        #2;
    endtask

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // monitor: every cycle with an outstanding expectation is compared
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.locked, bus.dir, bus.err_pulse, bus.wrap_pulse, bus.err_cnt, bus.wrap_cnt};
                n_vec++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got lock=%0b dir=%0b errp=%0b wrapp=%0b errc=%0d wrapc=%0d, expected lock=%0b dir=%0b errp=%0b wrapp=%0b errc=%0d wrapc=%0d",
                             $time, a.locked, a.dir, a.errp, a.wrapp, a.errc, a.wrapc,
                             e.locked, e.dir, e.errp, e.wrapp, e.errc, e.wrapc);
                end
            end
        end
    end

    initial begin
        int  r, val, v;
        bit  drift;
        bus.in_vld = 0;
        bus.in_val = 0;
        bus.clr    = 0;
        drift      = 0;
        drive(1, 0, 0, 0);
        drive(1, 1, 5, 1);
        settle;
        check("reset_state", {bus.locked, bus.dir, bus.err_pulse, bus.wrap_pulse, bus.err_cnt, bus.wrap_cnt}, 0);

        sample(0); sample(1); sample(2);
        settle;
        check("lock_up", bus.locked, 1);
        check("lock_up_dir", bus.dir, 0);
        for (int i = 3; i <= 15; i++) sample(i);
        sample(0);
        settle;
        check("wrap_up_pulse", bus.wrap_pulse, 1);
        check("wrap_up_cnt", bus.wrap_cnt, 1);
        sample(1);
        settle;
        check("wrap_once", bus.wrap_pulse, 0);
        check("no_err", bus.err_cnt, 0);

        drive(1, 0, 0, 0);
        sample(3); sample(4); sample(5); sample(5);
        settle;
        check("hold_err_pulse", bus.err_pulse, 1);
        check("hold_unlock", bus.locked, 0);
        check("hold_err_cnt", bus.err_cnt, 1);
        sample(4); sample(3);
        settle;
        check("relock_down", bus.locked, 1);
        check("relock_dir", bus.dir, 1);
        sample(2); sample(1); sample(0); sample(15);
        settle;
        check("wrap_down_pulse", bus.wrap_pulse, 1);
        check("wrap_down_dir", bus.dir, 1);

        drive(1, 0, 0, 0);
        sample(7); drive(0, 0, 3, 0); sample(8); drive(0, 0, 9, 0); drive(0, 0, 1, 0); sample(9);
        settle;
        check("gap_lock", bus.locked, 1);

        drive(1, 0, 0, 0);
        sample(0);
        val = 0;
        for (int i = 0; i < SAT + 1; i++) begin
            sample(val + 1); sample(val + 2); sample(val + 2);
            val = (val + 2) & 15;
        end
        settle;
        check("err_saturate", bus.err_cnt, SAT);
        sample(val + 1); sample(val + 2); drive(0, 1, (val + 2) & 15, 1);
        settle;
        check("clr_wins_cnt", bus.err_cnt, 0);
        check("clr_keeps_pulse", bus.err_pulse, 1);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) drift = !drift;
            val = r < 70 ? (drift ? m_prev - 1 : m_prev + 1) :
                  r < 80 ? (drift ? m_prev + 1 : m_prev - 1) :
                  r < 90 ? m_prev : int'($urandom_range(0, 15));
            drive($urandom_range(0, 99) == 0, v[0], val & 15, v[0] && $urandom_range(0, 29) == 0);
        end

        drive(1, 0, 0, 0);
        sample(0); sample(1); sample(2); sample(3);
        drive(1, 1, 4, 0);
        settle;
        check("rst_while_locked", {bus.locked, bus.dir, bus.err_pulse, bus.wrap_pulse, bus.err_cnt, bus.wrap_cnt}, 0);
        sample(9); sample(10);
        settle;
        check("rst_reload_only", bus.locked, 0);
        drive(0, 0, 0, 0);

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
